// File: rtl/stos_ctrl.sv
// Push/pop arbiter and sequencer in front of the hardware stack (stos).
// Define STOS_CTRL_RR_EN for round-robin arbitration; fixed r0 priority otherwise.
module stos_ctrl #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         r0_req,
    input  logic                         r0_op,
    input  logic [DATA_W-1:0]            r0_wdata,
    output logic                         r0_ack,
    output logic                         r0_err,
    output logic [DATA_W-1:0]            r0_rdata,
    input  logic                         r1_req,
    input  logic                         r1_op,
    input  logic [DATA_W-1:0]            r1_wdata,
    output logic                         r1_ack,
    output logic                         r1_err,
    output logic [DATA_W-1:0]            r1_rdata,
    output logic                         stos_push,
    output logic                         stos_pop,
    output logic [DATA_W-1:0]            stos_data_in,
    input  logic [DATA_W-1:0]            stos_data_out,
    input  logic                         stos_full,
    input  logic                         stos_empty,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         busy,
    output logic                         ovf_sticky,
    output logic                         udf_sticky
);

    localparam int LVL_W = $clog2(DEPTH+1);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t            state;
    logic              win_q;
    logic              op_q;
    logic [DATA_W-1:0] wdata_q;
    logic              grant;
    logic              exec_ok;

`ifdef STOS_CTRL_RR_EN
    logic              last_grant;

    always_comb begin
        grant = !r0_req;
        if (r0_req && r1_req) begin
            grant = !last_grant;
        end
    end
`else
    always_comb begin
        grant = !r0_req;
    end
`endif

    always_comb begin
        exec_ok      = op_q ? !stos_empty : !stos_full;
        stos_push    = (state == EXEC) && !op_q && !stos_full;
        stos_pop     = (state == EXEC) &&  op_q && !stos_empty;
        stos_data_in = ((state == EXEC) && !op_q) ? wdata_q : '0;
        busy         = (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            win_q      <= 1'b0;
            op_q       <= 1'b0;
            wdata_q    <= '0;
            r0_ack     <= 1'b0;
            r0_err     <= 1'b0;
            r0_rdata   <= '0;
            r1_ack     <= 1'b0;
            r1_err     <= 1'b0;
            r1_rdata   <= '0;
            level      <= '0;
            ovf_sticky <= 1'b0;
            udf_sticky <= 1'b0;
`ifdef STOS_CTRL_RR_EN
            last_grant <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (r0_req || r1_req) begin
                        win_q   <= grant;
                        op_q    <= grant ? r1_op : r0_op;
                        wdata_q <= grant ? r1_wdata : r0_wdata;
`ifdef STOS_CTRL_RR_EN
                        last_grant <= grant;
`endif
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    r0_ack   <= !win_q;
                    r1_ack   <=  win_q;
                    r0_err   <= !win_q && !exec_ok;
                    r1_err   <=  win_q && !exec_ok;
                    r0_rdata <= (!win_q && op_q && exec_ok) ? stos_data_out : '0;
                    r1_rdata <= ( win_q && op_q && exec_ok) ? stos_data_out : '0;
                    // Stack flags override the local count if the two ever disagree.
                    if (!op_q) begin
                        if (stos_full) begin
                            ovf_sticky <= 1'b1;
                            level      <= LVL_W'(DEPTH);
                        end else if (level != LVL_W'(DEPTH)) begin
                            level <= level + LVL_W'(1);
                        end
                    end else begin
                        if (stos_empty) begin
                            udf_sticky <= 1'b1;
                            level      <= '0;
                        end else if (level != '0) begin
                            level <= level - LVL_W'(1);
                        end
                    end
                    state <= RESP;
                end
                RESP: begin
                    r0_ack   <= 1'b0;
                    r0_err   <= 1'b0;
                    r0_rdata <= '0;
                    r1_ack   <= 1'b0;
                    r1_err   <= 1'b0;
                    r1_rdata <= '0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stos_ctrl.sv
// Self-checking bench for stos_ctrl with a behavioural stack and a scoreboard.
module tb_stos_ctrl;

    localparam int DW    = 8;
    localparam int DEPTH = 32;
    localparam int LW    = $clog2(DEPTH+1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          r0_req = 1'b0, r0_op = 1'b0, r1_req = 1'b0, r1_op = 1'b0;
    logic [DW-1:0] r0_wdata = '0, r1_wdata = '0;
    logic          r0_ack, r0_err, r1_ack, r1_err;
    logic [DW-1:0] r0_rdata, r1_rdata;
    logic          stos_push, stos_pop, stos_full, stos_empty;
    logic [DW-1:0] stos_data_in, stos_data_out;
    logic [LW-1:0] level;
    logic          busy, ovf_sticky, udf_sticky;

    int checks = 0;
    int errors = 0;

    typedef struct packed { logic err; logic [DW-1:0] rdata; } exp_t;
    typedef struct packed { logic op; logic [DW-1:0] d; } req_t;

    logic [DW-1:0] ref_stk[$];
    exp_t          exp_q[$];
    req_t          pend0[$];
    req_t          pend1[$];

    stos_ctrl #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .r0_req(r0_req), .r0_op(r0_op), .r0_wdata(r0_wdata),
        .r0_ack(r0_ack), .r0_err(r0_err), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_op(r1_op), .r1_wdata(r1_wdata),
        .r1_ack(r1_ack), .r1_err(r1_err), .r1_rdata(r1_rdata),
        .stos_push(stos_push), .stos_pop(stos_pop),
        .stos_data_in(stos_data_in), .stos_data_out(stos_data_out),
        .stos_full(stos_full), .stos_empty(stos_empty),
        .level(level), .busy(busy),
        .ovf_sticky(ovf_sticky), .udf_sticky(udf_sticky)
    );

    always #5 clk = ~clk;

    // Behavioural stack sharing the system reset.
    logic [DW-1:0] mem [DEPTH];
    int            sp;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp <= 0;
        end else if (stos_push && sp < DEPTH) begin
            mem[sp] <= stos_data_in;
            sp      <= sp + 1;
        end else if (stos_pop && sp > 0) begin
            sp <= sp - 1;
        end
    end

    always_comb begin
        stos_full     = (sp == DEPTH);
        stos_empty    = (sp == 0);
        stos_data_out = (sp > 0) ? mem[sp-1] : '0;
    end

    function automatic void apply(input logic op, input logic [DW-1:0] d,
                                  output logic e, output logic [DW-1:0] r);
        r = '0;
        e = 1'b0;
        if (!op) begin
            if (ref_stk.size() >= DEPTH) e = 1'b1;
            else ref_stk.push_back(d);
        end else begin
            if (ref_stk.size() == 0) e = 1'b1;
            else r = ref_stk.pop_back();
        end
    endfunction

    task automatic drive(input int id, input logic v, input logic op, input logic [DW-1:0] d);
        if (id == 0) begin
            r0_req = v; r0_op = op; r0_wdata = d;
        end else begin
            r1_req = v; r1_op = op; r1_wdata = d;
        end
    endtask

    // Issues one request from an idle controller and checks strobe, ack and level.
    task automatic run_op(input int id, input logic op, input logic [DW-1:0] d);
        logic e, ack, err_o, oack, oerr;
        logic [DW-1:0] r, rd, ord, pdin;
        logic pp, pq;
        int lat;
        exp_t x;
        apply(op, d, e, r);
        exp_q.push_back('{err: e, rdata: r});
        drive(id, 1'b1, op, d);
        lat = 0; pp = 1'b0; pq = 1'b0; pdin = '0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            ack = (id == 0) ? r0_ack : r1_ack;
            if (ack === 1'b1) begin
                lat = c;
                break;
            end
            pp = stos_push; pq = stos_pop; pdin = stos_data_in;
        end
        x = exp_q.pop_front();
        checks++;
        if (lat != 2) begin
            errors++;
            $display("FAIL ack_latency id=%0d: got %0d cycles expected 2", id, lat);
        end
        if (lat != 0) begin
            err_o = (id == 0) ? r0_err : r1_err;
            rd    = (id == 0) ? r0_rdata : r1_rdata;
            oack  = (id == 0) ? r1_ack : r0_ack;
            oerr  = (id == 0) ? r1_err : r0_err;
            ord   = (id == 0) ? r1_rdata : r0_rdata;
            checks++;
            if (err_o !== x.err) begin
                errors++;
                $display("FAIL err id=%0d: got %b expected %b", id, err_o, x.err);
            end
            checks++;
            if (rd !== x.rdata) begin
                errors++;
                $display("FAIL rdata id=%0d: got %h expected %h", id, rd, x.rdata);
            end
            checks++;
            if (pp !== (!op && !x.err) || pq !== (op && !x.err)) begin
                errors++;
                $display("FAIL strobe id=%0d: got push=%b pop=%b expected push=%b pop=%b",
                         id, pp, pq, !op && !x.err, op && !x.err);
            end
            if (!op) begin
                checks++;
                if (pdin !== d) begin
                    errors++;
                    $display("FAIL data_in: got %h expected %h", pdin, d);
                end
            end
            checks++;
            if (oack !== 1'b0 || oerr !== 1'b0 || ord !== '0) begin
                errors++;
                $display("FAIL loser_quiet: got ack=%b err=%b rdata=%h expected 0 0 00", oack, oerr, ord);
            end
            checks++;
            if (level !== LW'(ref_stk.size())) begin
                errors++;
                $display("FAIL level: got %0d expected %0d", level, ref_stk.size());
            end
        end
        drive(id, 1'b0, op, d);
        @(negedge clk);
        checks++;
        if (r0_ack !== 1'b0 || r1_ack !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ack_pulse: got r0_ack=%b r1_ack=%b busy=%b expected 0 0 0", r0_ack, r1_ack, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({r0_ack, r0_err, r0_rdata, r1_ack, r1_err, r1_rdata, stos_push, stos_pop,
             stos_data_in, level, busy, ovf_sticky, udf_sticky} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got nonzero outputs (level=%0d busy=%b) expected all 0", level, busy);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_push_pop();
        run_op(0, 1'b0, 8'hA5);
        run_op(0, 1'b1, 8'h00);
    endtask

    task automatic test_underflow();
        run_op(0, 1'b1, 8'h00);
        checks++;
        if (udf_sticky !== 1'b1 || ovf_sticky !== 1'b0) begin
            errors++;
            $display("FAIL udf_sticky: got udf=%b ovf=%b expected 1 0", udf_sticky, ovf_sticky);
        end
        run_op(1, 1'b0, 8'h5A);
        run_op(1, 1'b1, 8'h00);
        checks++;
        if (udf_sticky !== 1'b1) begin
            errors++;
            $display("FAIL udf_sticky_hold: got %b expected 1", udf_sticky);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < DEPTH; i++) run_op(0, 1'b0, 8'(i));
        checks++;
        if (ovf_sticky !== 1'b0) begin
            errors++;
            $display("FAIL ovf_early: got %b expected 0", ovf_sticky);
        end
        run_op(0, 1'b0, 8'hFF);
        checks++;
        if (ovf_sticky !== 1'b1 || level !== LW'(DEPTH)) begin
            errors++;
            $display("FAIL overflow: got ovf=%b level=%0d expected 1 %0d", ovf_sticky, level, DEPTH);
        end
        for (int i = 0; i < DEPTH; i++) run_op(0, 1'b1, 8'h00);
    endtask

    task automatic test_conflict();
        int order[$];
        int acks, id;
        logic e;
        logic [DW-1:0] r;
`ifdef STOS_CTRL_RR_EN
        order = '{0, 1, 0, 1, 1};
`else
        order = '{0, 0, 0, 0, 1};
`endif
        acks = 0;
        drive(0, 1'b1, 1'b0, 8'hC0);
        drive(1, 1'b1, 1'b0, 8'hD0);
        for (int c = 0; c < 40 && acks < 5; c++) begin
            @(negedge clk);
            if (r0_ack === 1'b1 || r1_ack === 1'b1) begin
                id = (r1_ack === 1'b1) ? 1 : 0;
                apply(1'b0, id ? 8'hD0 : 8'hC0, e, r);
                checks++;
                if ((r0_ack & r1_ack) !== 1'b0 || id != order[acks]) begin
                    errors++;
                    $display("FAIL grant_order[%0d]: got r%0d (acks %b%b) expected r%0d",
                             acks, id, r1_ack, r0_ack, order[acks]);
                end
                checks++;
                if (level !== LW'(ref_stk.size())) begin
                    errors++;
                    $display("FAIL conflict_level: got %0d expected %0d", level, ref_stk.size());
                end
                acks++;
                if (acks == 4) r0_req = 1'b0;
                if (acks == 5) r1_req = 1'b0;
            end
        end
        checks++;
        if (acks != 5) begin
            errors++;
            $display("FAIL conflict_timeout: got %0d acks expected 5", acks);
        end
        r0_req = 1'b0;
        r1_req = 1'b0;
        @(negedge clk);
        while (ref_stk.size() > 0) run_op(0, 1'b1, 8'h00);
    endtask

    task automatic test_back_to_back();
        logic          opv [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [DW-1:0] dat [6] = '{8'h31, 8'h32, 8'h33, 8'h00, 8'h00, 8'h00};
        logic e;
        logic [DW-1:0] r;
        exp_t x;
        int idx, last;
        idx = 0;
        last = -1;
        apply(opv[0], dat[0], e, r);
        exp_q.push_back('{err: e, rdata: r});
        drive(0, 1'b1, opv[0], dat[0]);
        for (int c = 1; c <= 60 && idx < 6; c++) begin
            @(negedge clk);
            if (r0_ack === 1'b1) begin
                x = exp_q.pop_front();
                checks++;
                if (r0_err !== x.err || r0_rdata !== x.rdata) begin
                    errors++;
                    $display("FAIL b2b_data[%0d]: got err=%b rdata=%h expected err=%b rdata=%h",
                             idx, r0_err, r0_rdata, x.err, x.rdata);
                end
                if (last >= 0) begin
                    checks++;
                    if (c - last != 3) begin
                        errors++;
                        $display("FAIL b2b_spacing[%0d]: got %0d cycles expected 3", idx, c - last);
                    end
                end
                last = c;
                idx++;
                if (idx < 6) begin
                    apply(opv[idx], dat[idx], e, r);
                    exp_q.push_back('{err: e, rdata: r});
                    drive(0, 1'b1, opv[idx], dat[idx]);
                end else begin
                    drive(0, 1'b0, 1'b0, 8'h00);
                end
            end
        end
        checks++;
        if (idx != 6) begin
            errors++;
            $display("FAIL b2b_timeout: got %0d acks expected 6", idx);
        end
        drive(0, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        run_op(0, 1'b0, 8'h11);
        drive(0, 1'b1, 1'b0, 8'h22);
        @(negedge clk);
        checks++;
        if (stos_push !== 1'b1) begin
            errors++;
            $display("FAIL mid_exec_strobe: got %b expected 1", stos_push);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({stos_push, stos_pop, stos_data_in, level, busy, ovf_sticky, udf_sticky,
             r0_ack, r0_err, r0_rdata, r1_ack, r1_err, r1_rdata} !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got push=%b level=%0d busy=%b ovf=%b udf=%b expected all 0",
                     stos_push, level, busy, ovf_sticky, udf_sticky);
        end
        drive(0, 1'b0, 1'b0, 8'h00);
        ref_stk.delete();
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (r0_ack !== 1'b0 || busy !== 1'b0 || level !== '0) begin
                errors++;
                $display("FAIL discarded_req: got ack=%b busy=%b level=%0d expected 0 0 0", r0_ack, busy, level);
            end
        end
    endtask

    task automatic test_random();
        req_t p;
        logic e;
        logic [DW-1:0] r;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            checks++;
            if (stos_push === 1'b1 && stos_pop === 1'b1) begin
                errors++;
                $display("FAIL strobe_exclusive: got push=1 pop=1 expected at most one");
            end
            if (r0_ack === 1'b1) begin
                checks++;
                if (pend0.size() == 0) begin
                    errors++;
                    $display("FAIL r0_spurious_ack: got ack expected none");
                end else begin
                    p = pend0.pop_front();
                    apply(p.op, p.d, e, r);
                    if (r0_err !== e || r0_rdata !== r) begin
                        errors++;
                        $display("FAIL r0_rand: got err=%b rdata=%h expected err=%b rdata=%h", r0_err, r0_rdata, e, r);
                    end
                end
                r0_req = 1'b0;
            end
            if (r1_ack === 1'b1) begin
                checks++;
                if (pend1.size() == 0) begin
                    errors++;
                    $display("FAIL r1_spurious_ack: got ack expected none");
                end else begin
                    p = pend1.pop_front();
                    apply(p.op, p.d, e, r);
                    if (r1_err !== e || r1_rdata !== r) begin
                        errors++;
                        $display("FAIL r1_rand: got err=%b rdata=%h expected err=%b rdata=%h", r1_err, r1_rdata, e, r);
                    end
                end
                r1_req = 1'b0;
            end
            if (r0_ack === 1'b1 || r1_ack === 1'b1) begin
                checks++;
                if (level !== LW'(ref_stk.size())) begin
                    errors++;
                    $display("FAIL rand_level: got %0d expected %0d", level, ref_stk.size());
                end
            end
            if (c < 9980) begin
                if (r0_req === 1'b0 && $urandom_range(0, 2) == 0) begin
                    p.op = 1'($urandom_range(0, 1));
                    p.d  = 8'($urandom);
                    pend0.push_back(p);
                    drive(0, 1'b1, p.op, p.d);
                end
                if (r1_req === 1'b0 && $urandom_range(0, 2) == 0) begin
                    p.op = 1'($urandom_range(0, 1));
                    p.d  = 8'($urandom);
                    pend1.push_back(p);
                    drive(1, 1'b1, p.op, p.d);
                end
            end
        end
        checks++;
        if (pend0.size() != 0 || pend1.size() != 0) begin
            errors++;
            $display("FAIL missing_ack: got %0d/%0d outstanding expected 0/0", pend0.size(), pend1.size());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_push_pop();
        test_underflow();
        test_overflow();
        test_conflict();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
